// File: rtl/bank_sram_ctrl_pkg.sv
// Shared bank definitions: opcodes, offset states and
// the controller FSM encoding.
package bank_sram_ctrl_pkg;

  localparam logic [1:0] SC_OP_WR    = 2'd0;
  localparam logic [1:0] SC_OP_RD    = 2'd1;
  localparam logic [1:0] SC_OP_RD_LF = 2'd2;
  localparam logic [1:0] SC_OP_WB    = 2'd3;

  localparam logic [1:0] SC_ST_DIRTY = 2'b11;

  typedef enum logic [2:0] {
    SC_IDLE,
    SC_ACC0,
    SC_ACC1,
    SC_RD,
    SC_CAP,
    SC_RESP,
    SC_WB
  } sc_state_e;

endpackage

// File: rtl/bank_sram_ctrl_fsm.sv
// Bank controller sequencer: state register and
// next-state logic for the single outstanding request.
module bank_sram_ctrl_fsm
  import bank_sram_ctrl_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       accept_i,
  input  logic [1:0] op_i,
  input  logic       rsp_ready_i,
  input  logic       wb_ready_i,
  output sc_state_e  state_o
);

  sc_state_e state_q, state_d;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= SC_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SC_IDLE: if (accept_i) state_d = SC_ACC0;
      SC_ACC0: begin
        unique case (op_i)
          SC_OP_WR: state_d = SC_RESP;
          SC_OP_RD: state_d = SC_CAP;
          default:  state_d = SC_ACC1;
        endcase
      end
      SC_ACC1: state_d = (op_i == SC_OP_WB) ?
                         SC_CAP : SC_RD;
      SC_RD:   state_d = SC_CAP;
      SC_CAP:  state_d = (op_i == SC_OP_WB) ?
                         SC_WB : SC_RESP;
      SC_RESP: if (rsp_ready_i) state_d = SC_IDLE;
      SC_WB:   if (wb_ready_i) state_d = SC_IDLE;
      default: state_d = SC_IDLE;
    endcase
  end

  assign state_o = state_q;

endmodule

// File: rtl/bank_sram_ctrl.sv
// Bank SRAM controller: write, read, linefill and writeback.
// Define BANK_SRAM_CTRL_PERF_EN for per-opcode accept counters.
module bank_sram_ctrl
  import bank_sram_ctrl_pkg::*;
#(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 128
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                iq_sc_valid_i,
  output logic                iq_sc_ready_o,
  input  logic [1:0]          iq_sc_channel_id_i,
  input  logic [2:0]          iq_sc_opcode_i,
  input  logic [ADDR_W-1:0]   iq_sc_set_way_offset_i,
  input  logic [7:0]          iq_sc_wbuffer_id_i,
  input  logic [2:0]          iq_sc_xbar_rob_num_i,
  input  logic [1:0]          iq_sc_cacheline_state_offset0_i,
  input  logic [1:0]          iq_sc_cacheline_state_offset1_i,
  input  logic [DATA_W-1:0]   iq_sc_linefill_data_offset0_i,
  input  logic [DATA_W-1:0]   iq_sc_linefill_data_offset1_i,
  output logic [7:0]          wbuffer_rd_id_o,
  input  logic [DATA_W-1:0]   wbuffer_rdata_i,
  output logic                sram_cen_o,
  output logic                sram_wen_o,
  output logic [ADDR_W-1:0]   sram_addr_o,
  output logic [DATA_W-1:0]   sram_wdata_o,
  input  logic [DATA_W-1:0]   sram_rdata_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [1:0]          rsp_ch_id_o,
  output logic [2:0]          rsp_rob_num_o,
  output logic                rsp_is_write_o,
  output logic [DATA_W-1:0]   rsp_data_o,
  output logic                wb_valid_o,
  input  logic                wb_ready_i,
  output logic [ADDR_W-2:0]   wb_line_addr_o,
  output logic [2*DATA_W-1:0] wb_data_o,
  output logic [3:0][31:0]    perf_cnt_o
);

  sc_state_e           state;
  logic                accept;
  logic                unused_op2;

  logic [1:0]          ch_q;
  logic [1:0]          op_q;
  logic [ADDR_W-1:0]   off_q;
  logic [7:0]          wbid_q;
  logic [2:0]          rob_q;
  logic [1:0]          st0_q, st1_q;
  logic [DATA_W-1:0]   lf0_q, lf1_q;
  logic [DATA_W-1:0]   rsp_data_q;
  logic [DATA_W-1:0]   wb_lo_q, wb_hi_q;
  logic [ADDR_W-2:0]   line;

  assign accept     = iq_sc_valid_i && iq_sc_ready_o;
  assign unused_op2 = iq_sc_opcode_i[2];
  assign line       = off_q[ADDR_W-1:1];

  bank_sram_ctrl_fsm u_fsm (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .accept_i    (accept),
    .op_i        (op_q),
    .rsp_ready_i (rsp_ready_i),
    .wb_ready_i  (wb_ready_i),
    .state_o     (state)
  );

  always_ff @(posedge clk_i) begin
    if (accept) begin
      ch_q   <= iq_sc_channel_id_i;
      op_q   <= iq_sc_opcode_i[1:0];
      off_q  <= iq_sc_set_way_offset_i;
      wbid_q <= iq_sc_wbuffer_id_i;
      rob_q  <= iq_sc_xbar_rob_num_i;
      st0_q  <= iq_sc_cacheline_state_offset0_i;
      st1_q  <= iq_sc_cacheline_state_offset1_i;
      lf0_q  <= iq_sc_linefill_data_offset0_i;
      lf1_q  <= iq_sc_linefill_data_offset1_i;
    end
    // offset0 of a writeback returns while offset1 is read
    if (state == SC_ACC1 && op_q == SC_OP_WB)
      wb_lo_q <= sram_rdata_i;
    if (state == SC_CAP) begin
      if (op_q == SC_OP_WB) wb_hi_q <= sram_rdata_i;
      else                  rsp_data_q <= sram_rdata_i;
    end
  end

  always_comb begin
    sram_cen_o   = 1'b0;
    sram_wen_o   = 1'b0;
    sram_addr_o  = off_q;
    sram_wdata_o = wbuffer_rdata_i;
    unique case (1'b1)
      (state == SC_ACC0 && op_q == SC_OP_WR): begin
        sram_cen_o = 1'b1;
        sram_wen_o = 1'b1;
      end
      (state == SC_ACC0 && op_q == SC_OP_RD): begin
        sram_cen_o = 1'b1;
      end
      (state == SC_ACC0 && op_q == SC_OP_RD_LF): begin
        sram_cen_o   = (st0_q != SC_ST_DIRTY);
        sram_wen_o   = sram_cen_o;
        sram_addr_o  = {line, 1'b0};
        sram_wdata_o = lf0_q;
      end
      (state == SC_ACC0 && op_q == SC_OP_WB): begin
        sram_cen_o  = 1'b1;
        sram_addr_o = {line, 1'b0};
      end
      (state == SC_ACC1 && op_q == SC_OP_RD_LF): begin
        sram_cen_o   = (st1_q != SC_ST_DIRTY);
        sram_wen_o   = sram_cen_o;
        sram_addr_o  = {line, 1'b1};
        sram_wdata_o = lf1_q;
      end
      (state == SC_ACC1 && op_q == SC_OP_WB): begin
        sram_cen_o  = 1'b1;
        sram_addr_o = {line, 1'b1};
      end
      (state == SC_RD): begin
        sram_cen_o = 1'b1;
      end
      default: ;
    endcase
  end

  assign iq_sc_ready_o   = (state == SC_IDLE);
  assign wbuffer_rd_id_o = wbid_q;
  assign rsp_valid_o     = (state == SC_RESP);
  assign rsp_ch_id_o     = ch_q;
  assign rsp_rob_num_o   = rob_q;
  assign rsp_is_write_o  = (op_q == SC_OP_WR);
  assign rsp_data_o      = rsp_is_write_o ? '0 : rsp_data_q;
  assign wb_valid_o      = (state == SC_WB);
  assign wb_line_addr_o  = line;
  assign wb_data_o       = {wb_hi_q, wb_lo_q};

`ifdef BANK_SRAM_CTRL_PERF_EN
  logic [3:0][31:0] perf_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni)
      perf_q <= '0;
    else if (accept)
      perf_q[iq_sc_opcode_i[1:0]] <=
        perf_q[iq_sc_opcode_i[1:0]] + 32'd1;
  end

  assign perf_cnt_o = perf_q;
`else
  assign perf_cnt_o = '0;
`endif

endmodule

// File: tb/tb_bank_sram_ctrl.sv
// Directed bench for bank_sram_ctrl with a behavioural
// SRAM and write-buffer model.
module tb_bank_sram_ctrl;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          valid, ready;
  logic [1:0]    ch;
  logic [2:0]    op;
  logic [6:0]    off;
  logic [7:0]    wbid;
  logic [2:0]    rob;
  logic [1:0]    st0, st1;
  logic [127:0]  lf0, lf1;
  logic [7:0]    wbuf_id;
  logic [127:0]  wbuf_rdata;
  logic          cen, wen;
  logic [6:0]    addr;
  logic [127:0]  wdata, rdata;
  logic          rsp_valid, rsp_ready;
  logic [1:0]    rsp_ch;
  logic [2:0]    rsp_rob;
  logic          rsp_is_write;
  logic [127:0]  rsp_data;
  logic          wb_valid, wb_ready;
  logic [5:0]    wb_line;
  logic [255:0]  wb_data;
  logic [3:0][31:0] perf;

  always #5 clk = ~clk;

  bank_sram_ctrl dut (
    .clk_i                           (clk),
    .rst_ni                          (rst_n),
    .iq_sc_valid_i                   (valid),
    .iq_sc_ready_o                   (ready),
    .iq_sc_channel_id_i              (ch),
    .iq_sc_opcode_i                  (op),
    .iq_sc_set_way_offset_i          (off),
    .iq_sc_wbuffer_id_i              (wbid),
    .iq_sc_xbar_rob_num_i            (rob),
    .iq_sc_cacheline_state_offset0_i (st0),
    .iq_sc_cacheline_state_offset1_i (st1),
    .iq_sc_linefill_data_offset0_i   (lf0),
    .iq_sc_linefill_data_offset1_i   (lf1),
    .wbuffer_rd_id_o                 (wbuf_id),
    .wbuffer_rdata_i                 (wbuf_rdata),
    .sram_cen_o                      (cen),
    .sram_wen_o                      (wen),
    .sram_addr_o                     (addr),
    .sram_wdata_o                    (wdata),
    .sram_rdata_i                    (rdata),
    .rsp_valid_o                     (rsp_valid),
    .rsp_ready_i                     (rsp_ready),
    .rsp_ch_id_o                     (rsp_ch),
    .rsp_rob_num_o                   (rsp_rob),
    .rsp_is_write_o                  (rsp_is_write),
    .rsp_data_o                      (rsp_data),
    .wb_valid_o                      (wb_valid),
    .wb_ready_i                      (wb_ready),
    .wb_line_addr_o                  (wb_line),
    .wb_data_o                       (wb_data),
    .perf_cnt_o                      (perf)
  );

  assign wbuf_rdata = (wbuf_id == 8'h12) ?
                      128'hDEAD : {120'h0, wbuf_id};

  logic [127:0] mem [128];
  int wr_cnt [128];
  int rd_cnt [128];
  int acc_cnt = 0;
  int cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cen) begin
      acc_cnt <= acc_cnt + 1;
      if (wen) begin
        mem[addr]    <= wdata;
        wr_cnt[addr] <= wr_cnt[addr] + 1;
      end else begin
        rdata        <= mem[addr];
        rd_cnt[addr] <= rd_cnt[addr] + 1;
      end
    end
  end

`ifdef BANK_SRAM_CTRL_PERF_EN
  localparam int EXP_P1 = 3;
  localparam int EXP_P3 = 1;
`else
  localparam int EXP_P1 = 0;
  localparam int EXP_P3 = 0;
`endif

  int n_run  = 0;
  int n_fail = 0;
  int t_acc  = 0;

  task automatic check(input string tag,
                       input logic [255:0] got,
                       input logic [255:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic issue(input logic [2:0] o,
                       input logic [6:0] a,
                       input logic [7:0] w,
                       input logic [2:0] r,
                       input logic [1:0] c,
                       input logic [1:0] s0,
                       input logic [1:0] s1,
                       input logic [127:0] l0,
                       input logic [127:0] l1);
    int n = 0;
    @(negedge clk);
    while (!ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("issue_ready", ready, 1);
    valid = 1; op = o; off = a; wbid = w;
    rob = r; ch = c; st0 = s0; st1 = s1;
    lf0 = l0; lf1 = l1;
    t_acc = cyc;
    @(posedge clk);
    #1;
    valid = 0; op = 0; off = 0; wbid = 0;
    rob = 0; ch = 0; st0 = 0; st1 = 0;
    lf0 = '0; lf1 = '0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        lat = cyc - t_acc;
        break;
      end
    end
    if (lat < 0) check("rsp_timeout", 0, 1);
  endtask

  task automatic wait_wb(output int lat);
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (wb_valid) begin
        lat = cyc - t_acc;
        break;
      end
    end
    if (lat < 0) check("wb_timeout", 0, 1);
  endtask

  task automatic ack_rsp();
    rsp_ready = 1;
    @(posedge clk);
    #1 rsp_ready = 0;
    @(negedge clk);
    check("rsp_next_ready", ready, 1);
    check("rsp_dropped", rsp_valid, 0);
  endtask

  task automatic ack_wb();
    wb_ready = 1;
    @(posedge clk);
    #1 wb_ready = 0;
    @(negedge clk);
    check("wb_next_ready", ready, 1);
    check("wb_dropped", wb_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: sim time exceeded");
    $fatal(1);
  end

  initial begin
    int lat, s_acc, s_a, s_b, s_c;
    logic [127:0] x, y;
    rst_n = 0; valid = 0; rsp_ready = 0; wb_ready = 0;
    op = 0; off = 0; wbid = 0; rob = 0; ch = 0;
    st0 = 0; st1 = 0; lf0 = '0; lf1 = '0;
    for (int i = 0; i < 128; i++) begin
      wr_cnt[i] = 0;
      rd_cnt[i] = 0;
      mem[i] <= {16{i[7:0]}};
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cen", cen, 0);
    check("rst_wen", wen, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_perf", perf, 0);
    rst_n = 1;
    @(negedge clk);
    check("rst_ready", ready, 1);

    // read
    mem[7'h25] <= {16{8'hA5}};
    s_acc = acc_cnt; s_a = rd_cnt[7'h25];
    issue(3'd1, 7'h25, 8'h00, 3'd5, 2'd2,
          2'd0, 2'd0, '0, '0);
    wait_rsp(lat);
    check("op1_lat", lat, 3);
    check("op1_data", rsp_data, {16{8'hA5}});
    check("op1_rob", rsp_rob, 3'd5);
    check("op1_ch", rsp_ch, 2'd2);
    check("op1_isw", rsp_is_write, 0);
    check("op1_rd", rd_cnt[7'h25] - s_a, 1);
    check("op1_acc", acc_cnt - s_acc, 1);
    repeat (2) @(negedge clk);
    check("op1_hold_v", rsp_valid, 1);
    check("op1_hold_d", rsp_data, {16{8'hA5}});
    check("op1_hold_rdy", ready, 0);
    ack_rsp();

    // write, opcode[2] set must be ignored
    s_acc = acc_cnt; s_a = wr_cnt[7'h33];
    issue(3'd4, 7'h33, 8'h12, 3'd3, 2'd1,
          2'd0, 2'd0, '0, '0);
    wait_rsp(lat);
    check("op0_lat", lat, 2);
    check("op0_isw", rsp_is_write, 1);
    check("op0_data", rsp_data, 0);
    check("op0_wbid", wbuf_id, 8'h12);
    check("op0_rob", rsp_rob, 3'd3);
    check("op0_mem", mem[7'h33], 128'hDEAD);
    check("op0_wr", wr_cnt[7'h33] - s_a, 1);
    check("op0_acc", acc_cnt - s_acc, 1);
    ack_rsp();

    // linefill with offset1 dirty
    mem[7'h21] <= 128'h0BAD;
    s_acc = acc_cnt;
    s_a = wr_cnt[7'h20]; s_b = wr_cnt[7'h21];
    s_c = rd_cnt[7'h20];
    issue(3'd2, 7'h20, 8'h00, 3'd1, 2'd3,
          2'b00, 2'b11, 128'hF00D_0000, 128'hF00D_0001);
    wait_rsp(lat);
    check("op2d_lat", lat, 5);
    check("op2d_data", rsp_data, 128'hF00D_0000);
    check("op2d_mem0", mem[7'h20], 128'hF00D_0000);
    check("op2d_mem1", mem[7'h21], 128'h0BAD);
    check("op2d_wr0", wr_cnt[7'h20] - s_a, 1);
    check("op2d_wr1", wr_cnt[7'h21] - s_b, 0);
    check("op2d_rd0", rd_cnt[7'h20] - s_c, 1);
    check("op2d_acc", acc_cnt - s_acc, 2);
    ack_rsp();

    // linefill, both clean, offset 1 requested
    s_acc = acc_cnt;
    issue(3'd2, 7'h0B, 8'h00, 3'd7, 2'd0,
          2'b01, 2'b10, 128'hCAFE_000A, 128'hCAFE_000B);
    wait_rsp(lat);
    check("op2c_lat", lat, 5);
    check("op2c_data", rsp_data, 128'hCAFE_000B);
    check("op2c_mem0", mem[7'h0A], 128'hCAFE_000A);
    check("op2c_mem1", mem[7'h0B], 128'hCAFE_000B);
    check("op2c_acc", acc_cnt - s_acc, 3);
    ack_rsp();

    // writeback of the last line, ready held low
    x = 128'h1111_7E7E; y = 128'h2222_7F7F;
    mem[7'h7E] <= x;
    mem[7'h7F] <= y;
    s_acc = acc_cnt;
    s_a = rd_cnt[7'h7E]; s_b = rd_cnt[7'h7F];
    issue(3'd3, 7'h7E, 8'h00, 3'd0, 2'd0,
          2'd0, 2'd0, '0, '0);
    wait_wb(lat);
    check("op3_lat", lat, 4);
    check("op3_data", wb_data, {y, x});
    check("op3_line", wb_line, 6'h3F);
    check("op3_rd0", rd_cnt[7'h7E] - s_a, 1);
    check("op3_rd1", rd_cnt[7'h7F] - s_b, 1);
    check("op3_acc", acc_cnt - s_acc, 2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("op3_hold_v", wb_valid, 1);
      check("op3_hold_d", wb_data, {y, x});
      check("op3_hold_rdy", ready, 0);
    end
    ack_wb();

    // reset during linefill ACC1
    issue(3'd2, 7'h10, 8'h00, 3'd2, 2'd1,
          2'd0, 2'd0, 128'h5, 128'h6);
    @(negedge clk);
    @(negedge clk);
    check("mid_acc1_cen", cen, 1);
    check("mid_acc1_addr", addr, 7'h11);
    rst_n = 0;
    s_c = rd_cnt[7'h10];
    @(negedge clk);
    s_acc = acc_cnt;
    check("mid_rst_cen", cen, 0);
    check("mid_rst_perf", perf, 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    check("mid_ready", ready, 1);
    repeat (3) @(negedge clk);
    check("mid_acc", acc_cnt - s_acc, 0);
    check("mid_rd", rd_cnt[7'h10] - s_c, 0);
    check("mid_rsp_valid", rsp_valid, 0);
    check("mid_wb_valid", wb_valid, 0);

    // counters: three reads and one writeback
    for (int i = 1; i <= 3; i++) begin
      issue(3'd1, 7'(i), 8'h00, 3'd0, 2'd0,
            2'd0, 2'd0, '0, '0);
      wait_rsp(lat);
      check("perf_rd_data", rsp_data, {16{8'(i)}});
      ack_rsp();
    end
    issue(3'd3, 7'h40, 8'h00, 3'd0, 2'd0,
          2'd0, 2'd0, '0, '0);
    wait_wb(lat);
    ack_wb();
    check("perf0", perf[0], 0);
    check("perf1", perf[1], EXP_P1);
    check("perf2", perf[2], 0);
    check("perf3", perf[3], EXP_P3);

    $display("[TB] %0d tests run, %0d failed",
             n_run, n_fail);
    $finish;
  end

endmodule
